gf180mcu_fd_sc_mcu7t5v0__nor2_bist_ctrl: RTL

//  Built-in self-test controller for a 2-input NOR cell.
//  - Drives the cell inputs A1/A2 with the exhaustive 4-vector set.
//  - Waits a programmable settle time, then samples the cell output ZN and compares it against ~(A1|A2).
//  - Counts mismatches and reports pass/fail.
//  - Sits beside a nor2 instance in the library silicon-test / characterization harness.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__nor2_bist_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor2_bist_ctrl.sv
// Built-in self-test controller for a 2-input NOR cell.
// Applies the exhaustive Gray-ordered vector set {A2,A1} = 00,01,11,10 for
// N_ITER passes. Each vector is held SETTLE+1 cycles, and then ZN is compared
// against ~(A1|A2). The controller records a saturating mismatch count and
// the first failing vector, and reports pass/fail at the end of the run.
// Ports:
//   CLK       clock, rising edge
//   RN        synchronous reset, active-low (aborts a run, no DONE)
//   START     start request, honoured only while idle
//   DRV_A1/2  registered drives to the cell under test
//   SMP_ZN    cell output, sampled at the end of each vector slot
//   BUSY      run in progress
//   DONE      one-cycle end-of-run pulse
//   PASS      last run had zero mismatches
//   ERR_CNT   saturating mismatch count
//   FAIL_VLD  at least one mismatch in this run
//   FAIL_VEC  {A2,A1} of the first mismatching vector
module gf180mcu_fd_sc_mcu7t5v0__nor2_bist_ctrl #(
  parameter int unsigned N_ITER = 1,
  parameter int unsigned SETTLE = 0,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  output logic             DRV_A1,
  output logic             DRV_A2,
  input  logic             SMP_ZN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VLD,
  output logic [1:0]       FAIL_VEC
);

  localparam int unsigned SLOT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned ITER_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [1:0]          vidx_q, vidx_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [1:0]          drv_q, drv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                fvld_q, fvld_d;
  logic [1:0]          fvec_q, fvec_d;

  // Vector index -> Gray-ordered {A2,A1}: 0->00, 1->01, 2->11, 3->10
  function automatic logic [1:0] gray_vec(input logic [1:0] idx);
    return {idx[1], idx[1] ^ idx[0]};
  endfunction

  logic slot_end_c, last_c, expect_zn_c, mismatch_c;

  always_comb begin
    slot_end_c  = (slot_q == SLOT_W'(SETTLE));
    last_c      = (vidx_q == 2'd3) && (iter_q == ITER_W'(N_ITER - 1));
    // Only vector 00 drives ZN high on a good NOR cell
    expect_zn_c = (vidx_q == 2'd0);
    // Case inequality so that an unknown ZN is treated as a mismatch
    mismatch_c  = (SMP_ZN !== expect_zn_c);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    vidx_d  = vidx_q;
    iter_d  = iter_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;

    unique case (state_q)
      IDLE: begin
        drv_d  = 2'b00;
        busy_d = 1'b0;
        if (START) begin
          state_d = RUN;
          slot_d  = '0;
          vidx_d  = 2'd0;
          iter_d  = '0;
          drv_d   = gray_vec(2'd0);
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fvld_d  = 1'b0;
          fvec_d  = 2'b00;
        end
      end

      RUN: begin
        if (slot_end_c) begin
          slot_d = '0;
          if (mismatch_c) begin
            err_d = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
            if (!fvld_q) begin
              fvld_d = 1'b1;
              fvec_d = gray_vec(vidx_q);
            end
          end
          vidx_d = vidx_q + 2'd1;
          if (vidx_q == 2'd3) begin
            iter_d = iter_q + ITER_W'(1);
          end
          if (last_c) begin
            state_d = FIN;
            iter_d  = '0;
            drv_d   = 2'b00;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Includes the final sample's outcome
            pass_d  = (err_d == '0);
          end else begin
            drv_d = gray_vec(vidx_q + 2'd1);
          end
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= IDLE;
      slot_q  <= '0;
      vidx_q  <= 2'd0;
      iter_q  <= '0;
      drv_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      fvec_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      vidx_q  <= vidx_d;
      iter_q  <= iter_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
    end
  end

  assign DRV_A1   = drv_q[0];
  assign DRV_A2   = drv_q[1];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VLD = fvld_q;
  assign FAIL_VEC = fvec_q;

endmodule
